// File: rtl/riscv_sim_ctrl.sv
// ============================================================================
//  Module      : riscv_sim_ctrl
//  Description : Run controller for riscv_top. Staggers per-domain core resets,
//                counts RUN cycles, detects tohost exit stores, and runs a
//                watchdog that ends the run if the program never exits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module riscv_sim_ctrl #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                CNT_W          = 32,
    parameter int                N_RST          = 2,
    parameter int                RESET_CYCLES   = 2,
    parameter int                STAGGER        = 1,
    parameter int                TIMEOUT_CYCLES = 50,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_0FFC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [N_RST-1:0]  core_reset,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-2:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count
);

    // Hold-counter value at which the last core domain is released.
    localparam int          c_last_rel = RESET_CYCLES - 1 + (N_RST - 1) * STAGGER;
    localparam int          c_hold_w   = $clog2(c_last_rel + 2);
    localparam bit          c_wd_en    = (TIMEOUT_CYCLES != 0);
    localparam logic [63:0] c_wd_last  = 64'(TIMEOUT_CYCLES) - 64'd1;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_hold_w-1:0] r_hold;
    logic [N_RST-1:0]    r_core_reset;
    logic [N_RST-1:0]    w_rel_due;
    logic                r_running;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic [DATA_W-2:0]   r_exit_code;
    logic [CNT_W-1:0]    r_cycle_count;
    logic                w_exit;
    logic                w_wdog;
    logic                w_hold_end;

    generate
        for (genvar gi = 0; gi < N_RST; gi++) begin : g_core_rst
            localparam int c_rel = RESET_CYCLES - 1 + gi * STAGGER;
            assign w_rel_due[gi] = (r_hold >= c_hold_w'(c_rel));
        end
    endgenerate

    assign w_hold_end = (r_hold >= c_hold_w'(c_last_rel));

    // Stores with bit 0 clear are console/poll traffic and never end the run.
    assign w_exit = (r_state == ST_RUN) && mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    assign w_wdog = c_wd_en && (r_state == ST_RUN) && (64'(r_cycle_count) == c_wd_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HOLD: if (w_hold_end)       w_state_nxt = ST_RUN;
            ST_RUN:  if (w_exit || w_wdog) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold        <= '0;
            r_core_reset  <= '1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_exit_code   <= '0;
            r_cycle_count <= '0;
        end else begin
            r_running <= (w_state_nxt == ST_RUN);
            if (r_state == ST_HOLD) begin
                r_hold       <= r_hold + c_hold_w'(1);
                r_core_reset <= r_core_reset & ~w_rel_due;
            end
            if (r_state == ST_RUN) begin
                if (!(&r_cycle_count)) begin
                    r_cycle_count <= r_cycle_count + CNT_W'(1);
                end
                // Exit store takes priority over a coincident watchdog expiry.
                if (w_exit) begin
                    r_done      <= 1'b1;
                    r_exit_code <= mem_wdata[DATA_W-1:1];
                    r_pass      <= ~|mem_wdata[DATA_W-1:1];
                    r_timeout   <= 1'b0;
                end else if (w_wdog) begin
                    r_done      <= 1'b1;
                    r_exit_code <= '0;
                    r_pass      <= 1'b0;
                    r_timeout   <= 1'b1;
                end
            end
        end
    end

    assign core_reset  = r_core_reset;
    assign running     = r_running;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign exit_code   = r_exit_code;
    assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_riscv_sim_ctrl.sv
// ============================================================================
//  Module      : tb_riscv_sim_ctrl
//  Description : Self-checking bench for riscv_sim_ctrl (default and staggered
//                three-domain configurations).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_riscv_sim_ctrl;

    localparam int          RC     = 2;
    localparam int          STG    = 1;
    localparam int          NR     = 2;
    localparam int          TO     = 50;
    localparam logic [31:0] TOHOST = 32'h0000_0FFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-configuration instance.
    logic        reset     = 1'b1;
    logic        mem_we    = 1'b0;
    logic [31:0] mem_addr  = '0;
    logic [31:0] mem_wdata = '0;
    logic [1:0]  a_core_reset;
    logic        a_running, a_done, a_pass, a_timeout;
    logic [30:0] a_exit_code;
    logic [31:0] a_cycle_count;

    riscv_sim_ctrl dut_a (
        .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_reset(a_core_reset), .running(a_running), .done(a_done), .pass(a_pass),
        .timeout(a_timeout), .exit_code(a_exit_code), .cycle_count(a_cycle_count)
    );

    // Three domains, stagger 2, no watchdog, 4-bit counter.
    logic        b_reset = 1'b1;
    logic        b_we    = 1'b0;
    logic [31:0] b_addr  = '0;
    logic [31:0] b_wdata = '0;
    logic [2:0]  b_core_reset;
    logic        b_running, b_done, b_pass, b_timeout;
    logic [30:0] b_exit_code;
    logic [3:0]  b_cycle_count;

    riscv_sim_ctrl #(.N_RST(3), .STAGGER(2), .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(b_reset), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .core_reset(b_core_reset), .running(b_running), .done(b_done), .pass(b_pass),
        .timeout(b_timeout), .exit_code(b_exit_code), .cycle_count(b_cycle_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: tracks edges since reset release and the run outcome.
    int              m_n    = 0;
    bit              m_done = 1'b0;
    bit              m_pass = 1'b0;
    bit              m_to   = 1'b0;
    logic [30:0]     m_code = '0;
    longint unsigned m_cnt  = 0;

    function automatic int rel(int i);
        return RC - 1 + i * STG;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_n    <= 0;
            m_done <= 1'b0;
            m_pass <= 1'b0;
            m_to   <= 1'b0;
            m_code <= '0;
            m_cnt  <= 0;
        end else begin
            if (m_n > rel(NR - 1) && !m_done) begin
                if (mem_we && mem_addr == TOHOST && mem_wdata[0]) begin
                    m_done <= 1'b1;
                    m_code <= mem_wdata[31:1];
                    m_pass <= (mem_wdata[31:1] == 31'd0);
                    m_to   <= 1'b0;
                end else if (TO != 0 && m_cnt == longint'(TO - 1)) begin
                    m_done <= 1'b1;
                    m_to   <= 1'b1;
                    m_pass <= 1'b0;
                    m_code <= '0;
                end
                m_cnt <= (m_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
            end
            if (m_n < 1000000) m_n <= m_n + 1;
        end
    end

    function automatic logic [68:0] model_vec();
        logic [1:0] cr;
        logic       run;
        for (int i = 0; i < NR; i++) cr[i] = (m_n <= rel(i));
        run = (m_n > rel(NR - 1)) && !m_done;
        return {cr, run, m_done, m_pass, m_to, m_code, m_cnt[31:0]};
    endfunction

    function automatic logic [68:0] dut_vec();
        return {a_core_reset, a_running, a_done, a_pass, a_timeout, a_exit_code, a_cycle_count};
    endfunction

    // One clock, then compare the default instance against the model.
    task automatic step();
        @(negedge clk);
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL model_cmp t=%0t: dut=%h model=%h", $time, dut_vec(), model_vec());
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reset for two cycles then three edges: leaves default instance in RUN, cycle_count 0.
    task automatic reset_to_run();
        mem_we = 1'b0;
        reset  = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  cr;
        logic        run;
        logic        done;
        logic        pass;
        logic        to;
        logic [30:0] code;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(logic rst, logic we, logic [31:0] addr, logic [31:0] wdata,
                                logic [1:0] cr, logic run, logic done, logic pass, logic to,
                                logic [30:0] code, logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = addr; v.wdata = wdata;
        v.cr = cr; v.run = run; v.done = done; v.pass = pass; v.to = to;
        v.code = code; v.cnt = cnt;
        return v;
    endfunction

    vec_t       tbl [12];
    logic [2:0] b_exp_cr  [7] = '{3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000, 3'b000};
    logic       b_exp_run [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        //           rst we addr         wdata  cr     run done pass to code cnt
        tbl[0]  = mk(1, 0, 32'h0,       32'h0, 2'b11, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 32'h0,       32'h0, 2'b11, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 32'h0,       32'h0, 2'b11, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 32'h0,       32'h0, 2'b10, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 32'h0,       32'h0, 2'b00, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 32'h0,       32'h0, 2'b00, 1, 0, 0, 0, 0, 1);
        tbl[6]  = mk(0, 1, 32'h0FFC,    32'h6, 2'b00, 1, 0, 0, 0, 0, 2);
        tbl[7]  = mk(0, 1, 32'h0FF8,    32'h7, 2'b00, 1, 0, 0, 0, 0, 3);
        tbl[8]  = mk(0, 1, 32'h0FFC,    32'h7, 2'b00, 0, 1, 0, 0, 3, 4);
        tbl[9]  = mk(0, 0, 32'h0,       32'h0, 2'b00, 0, 1, 0, 0, 3, 4);
        tbl[10] = mk(0, 1, 32'h0FFC,    32'h1, 2'b00, 0, 1, 0, 0, 3, 4);
        tbl[11] = mk(1, 0, 32'h0,       32'h0, 2'b11, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            reset     = tbl[i].rst;
            mem_we    = tbl[i].we;
            mem_addr  = tbl[i].addr;
            mem_wdata = tbl[i].wdata;
            step();
            chk($sformatf("table[%0d]", i), 64'(dut_vec()),
                64'({tbl[i].cr, tbl[i].run, tbl[i].done, tbl[i].pass, tbl[i].to,
                     tbl[i].code, tbl[i].cnt}));
            chk($sformatf("table_hi[%0d]", i), 64'(a_core_reset), 64'(tbl[i].cr));
        end

        // Pass exit at RUN cycle 10.
        reset_to_run();
        repeat (10) step();
        mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'h1;
        step();
        mem_we = 1'b0;
        chk("pass_done", 64'(a_done), 64'd1);
        chk("pass_pass", 64'(a_pass), 64'd1);
        chk("pass_code", 64'(a_exit_code), 64'd0);
        chk("pass_cnt", 64'(a_cycle_count), 64'd11);
        repeat (3) step();
        chk("pass_frozen", 64'(a_cycle_count), 64'd11);
        chk("pass_running", 64'(a_running), 64'd0);

        // Watchdog after exactly 50 RUN cycles.
        reset_to_run();
        repeat (49) step();
        chk("wd_pre_done", 64'(a_done), 64'd0);
        step();
        chk("wd_done", 64'(a_done), 64'd1);
        chk("wd_timeout", 64'(a_timeout), 64'd1);
        chk("wd_pass", 64'(a_pass), 64'd0);
        chk("wd_cnt", 64'(a_cycle_count), 64'd50);

        // Exit store coinciding with watchdog expiry.
        reset_to_run();
        repeat (49) step();
        mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'h1;
        step();
        mem_we = 1'b0;
        chk("tie_done", 64'(a_done), 64'd1);
        chk("tie_timeout", 64'(a_timeout), 64'd0);
        chk("tie_pass", 64'(a_pass), 64'd1);

        // Reset mid-RUN, then after DONE.
        reset_to_run();
        repeat (20) step();
        chk("mid_cnt", 64'(a_cycle_count), 64'd20);
        reset = 1'b1;
        step();
        chk("mid_rst_cr", 64'(a_core_reset), 64'h3);
        chk("mid_rst_cnt", 64'(a_cycle_count), 64'd0);
        chk("mid_rst_run", 64'(a_running), 64'd0);
        step();
        reset = 1'b0;
        step();
        chk("mid_e0_cr", 64'(a_core_reset), 64'h3);
        step();
        chk("mid_e1_cr", 64'(a_core_reset), 64'h2);
        step();
        chk("mid_e2_cr", 64'(a_core_reset), 64'h0);
        chk("mid_e2_run", 64'(a_running), 64'd1);
        mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'h7;
        step();
        mem_we = 1'b0;
        chk("post_done", 64'(a_done), 64'd1);
        chk("post_code", 64'(a_exit_code), 64'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("post_rst_done", 64'(a_done), 64'd0);
        chk("post_rst_code", 64'(a_exit_code), 64'd0);
        chk("post_rst_cr", 64'(a_core_reset), 64'h3);

        // Staggered three-domain instance.
        b_reset = 1'b1;
        step();
        step();
        b_reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("b_cr_e%0d", k), 64'(b_core_reset), 64'(b_exp_cr[k]));
            chk($sformatf("b_run_e%0d", k), 64'(b_running), 64'(b_exp_run[k]));
        end
        for (int j = 1; j <= 100; j++) begin
            step();
            chk($sformatf("b_cnt_%0d", j), 64'(b_cycle_count), (j + 1 >= 15) ? 64'd15 : 64'(j + 1));
        end
        chk("b_no_done", 64'(b_done), 64'd0);
        chk("b_no_timeout", 64'(b_timeout), 64'd0);

        // Randomized traffic against the model.
        for (int r = 0; r < 800; r++) begin
            logic [31:0] w;
            reset  = ($urandom_range(0, 79) == 0) || (m_done && $urandom_range(0, 5) == 0);
            mem_we = 1'($urandom_range(0, 1));
            mem_addr = ($urandom_range(0, 1) == 1) ? TOHOST : 32'($urandom_range(0, 4095));
            w = $urandom;
            w[0] = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) w[31:1] = '0;
            mem_wdata = w;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
